// File: rtl/ws2811_transmitter.sv
// WS2811 serial transmitter: fetches per-pixel RGB from an external colour source
// via ledindex_o and emits frames of NUM_LEDS pixels, each preceded by a low reset gap.
module ws2811_transmitter #(
    parameter int unsigned NUM_LEDS = 64,
    parameter int unsigned T0H      = 20,
    parameter int unsigned T1H      = 40,
    parameter int unsigned TBIT     = 63,
    parameter int unsigned TRESET   = 3000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    input  logic [7:0] blue_i,
    output logic [7:0] ledindex_o,
    output logic       dout_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam int unsigned GapW = (TRESET > 1) ? $clog2(TRESET) : 1;
    localparam int unsigned BitW = (TBIT > 1) ? $clog2(TBIT) : 1;

    localparam logic [GapW-1:0] GapLast  = GapW'(TRESET - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(TBIT - 1);
    localparam logic [BitW-1:0] HighZero = BitW'(T0H);
    localparam logic [BitW-1:0] HighOne  = BitW'(T1H);
    localparam logic [7:0]      PixLast  = 8'(NUM_LEDS - 1);
    localparam logic [7:0]      FirstIdx = (NUM_LEDS > 1) ? 8'd1 : 8'd0;
    localparam logic [8:0]      NumLeds9 = 9'(NUM_LEDS);

    typedef enum logic [1:0] {StIdle, StGap, StSend} state_e;

    state_e          state_q, state_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
    logic [4:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      pix_q, pix_d;
    logic [23:0]     shift_q, shift_d;
    logic [7:0]      ledindex_q, ledindex_d;
    logic            dout_q, dout_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;

    // Address two pixels ahead of the one finishing, wrapping to 0 past the last pixel.
    logic [8:0] prefetch_idx;
    assign prefetch_idx = {1'b0, pix_q} + 9'd2;

    // Next-state logic; outputs are derived from next-state values so they register cleanly.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        pix_d        = pix_q;
        shift_d      = shift_q;
        ledindex_d   = ledindex_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                ledindex_d = 8'd0;
                if (enable_i) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    shift_d    = {red_i, green_i, blue_i};
                    pix_d      = 8'd0;
                    ledindex_d = FirstIdx;
                    bit_cnt_d  = '0;
                    bit_idx_d  = 5'd0;
                    state_d    = StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            StSend: begin
                if (bit_cnt_q == BitLast) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 5'd23) begin
                        bit_idx_d = 5'd0;
                        if (pix_q == PixLast) begin
                            frame_done_d = 1'b1;
                            ledindex_d   = 8'd0;
                            gap_cnt_d    = '0;
                            state_d      = enable_i ? StGap : StIdle;
                        end else begin
                            shift_d    = {red_i, green_i, blue_i};
                            pix_d      = pix_q + 8'd1;
                            ledindex_d = (prefetch_idx < NumLeds9) ? prefetch_idx[7:0] : 8'd0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                        shift_d   = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        dout_d = (state_d == StSend) && (bit_cnt_d < (shift_d[23] ? HighOne : HighZero));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            gap_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            bit_idx_q    <= 5'd0;
            pix_q        <= 8'd0;
            shift_q      <= 24'd0;
            ledindex_q   <= 8'd0;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            pix_q        <= pix_d;
            shift_q      <= shift_d;
            ledindex_q   <= ledindex_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ledindex_o   = ledindex_q;
    assign dout_o       = dout_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ws2811_transmitter.sv
// Bench for ws2811_transmitter: two instances (3-pixel and 256-pixel) fed by colour
// sources with 16-cycle latency, every output compared each cycle to a waveform model.
module tb_ws2811_transmitter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic [7:0] led_a, led_b;
    logic       dout_a, dout_b, busy_a, busy_b, fd_a, fd_b;

    logic [23:0] tab [256];
    logic [7:0]  pipe_a [16];
    logic [7:0]  pipe_b [16];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ws2811_transmitter #(
        .NUM_LEDS(3), .T0H(3), .T1H(6), .TBIT(10), .TRESET(20)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_a),
        .red_i(red_a), .green_i(green_a), .blue_i(blue_a),
        .ledindex_o(led_a), .dout_o(dout_a), .busy_o(busy_a), .frame_done_o(fd_a)
    );

    ws2811_transmitter #(
        .NUM_LEDS(256), .T0H(1), .T1H(2), .TBIT(4), .TRESET(20)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b),
        .red_i(red_b), .green_i(green_b), .blue_i(blue_b),
        .ledindex_o(led_b), .dout_o(dout_b), .busy_o(busy_b), .frame_done_o(fd_b)
    );

    // Colour sources answering ledindex 16 cycles late.
    always @(posedge clk) begin
        pipe_a[0] <= led_a;
        pipe_b[0] <= led_b;
        for (int i = 1; i < 16; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign {red_a, green_a, blue_a} = tab[pipe_a[15]];
    assign {red_b, green_b, blue_b} = tab[pipe_b[15]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int t, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Expected outputs at sample t after enable is first seen, for nframes back-to-back frames.
    function automatic void model(input bit sel_b, input int t, input int nframes,
                                  output logic e_dout, output logic e_busy,
                                  output logic e_fd, output logic [7:0] e_led);
        int n, t0h, t1h, tbit, trst, len, u, b, c, p, k;
        logic bitv;
        if (sel_b) begin
            n = 256; t0h = 1; t1h = 2; tbit = 4; trst = 20;
        end else begin
            n = 3; t0h = 3; t1h = 6; tbit = 10; trst = 20;
        end
        len    = trst + n * 24 * tbit;
        e_fd   = (t > 0) && (t % len == 0) && (t / len <= nframes);
        e_busy = (t < nframes * len);
        e_dout = 1'b0;
        e_led  = 8'd0;
        if (e_busy) begin
            u = t % len;
            if (u >= trst) begin
                b      = (u - trst) / tbit;
                c      = (u - trst) % tbit;
                p      = b / 24;
                k      = b % 24;
                bitv   = tab[p][23-k];
                e_dout = (c < (bitv ? t1h : t0h));
                e_led  = (p + 1 < n) ? 8'(p + 1) : 8'd0;
            end
        end
    endfunction

    task automatic run(input bit sel_b, input int nframes, input int drop_at,
                       input int nsamples);
        logic e_dout, e_busy, e_fd;
        logic [7:0] e_led;
        if (sel_b) en_b = 1'b1; else en_a = 1'b1;
        for (int t = 0; t < nsamples; t++) begin
            if (t == drop_at) begin
                if (sel_b) en_b = 1'b0; else en_a = 1'b0;
            end
            step();
            model(sel_b, t, nframes, e_dout, e_busy, e_fd, e_led);
            if (sel_b) begin
                chk("b_dout", t, 32'(dout_b), 32'(e_dout));
                chk("b_busy", t, 32'(busy_b), 32'(e_busy));
                chk("b_frame_done", t, 32'(fd_b), 32'(e_fd));
                chk("b_ledindex", t, 32'(led_b), 32'(e_led));
            end else begin
                chk("a_dout", t, 32'(dout_a), 32'(e_dout));
                chk("a_busy", t, 32'(busy_a), 32'(e_busy));
                chk("a_frame_done", t, 32'(fd_a), 32'(e_fd));
                chk("a_ledindex", t, 32'(led_a), 32'(e_led));
            end
        end
    endtask

    task automatic randomize_tab(input int n);
        for (int i = 0; i < n; i++) tab[i] = 24'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        randomize_tab(256);

        // Reset state.
        repeat (5) step();
        chk("rst_dout", 0, 32'(dout_a), 32'd0);
        chk("rst_busy", 0, 32'(busy_a), 32'd0);
        chk("rst_frame_done", 0, 32'(fd_a), 32'd0);
        chk("rst_ledindex", 0, 32'(led_a), 32'd0);
        chk("rst_b_busy", 0, 32'(busy_b), 32'd0);

        // Idle with enable low.
        rst_n = 1'b1;
        for (int t = 0; t < 100; t++) begin
            step();
            chk("idle_dout", t, 32'(dout_a), 32'd0);
            chk("idle_busy", t, 32'(busy_a), 32'd0);
            chk("idle_frame_done", t, 32'(fd_a), 32'd0);
            chk("idle_ledindex", t, 32'(led_a), 32'd0);
        end

        // Single frame, enable dropped during the gap.
        randomize_tab(3);
        run(1'b0, 1, 1, 800);

        // Continuous frames, enable dropped mid-way through the second frame.
        randomize_tab(3);
        run(1'b0, 2, 1000, 2 * 740 + 60);

        // Reset at cycle 4 of a '1' bit.
        randomize_tab(3);
        tab[0][23] = 1'b1;
        run(1'b0, 1, 1000, 25);
        chk("midbit_high", 24, 32'(dout_a), 32'd1);
        rst_n = 1'b0;
        step();
        chk("midbit_rst_dout", 0, 32'(dout_a), 32'd0);
        chk("midbit_rst_busy", 0, 32'(busy_a), 32'd0);
        chk("midbit_rst_ledindex", 0, 32'(led_a), 32'd0);
        chk("midbit_rst_frame_done", 0, 32'(fd_a), 32'd0);
        rst_n = 1'b1;
        run(1'b0, 1, 1, 800);

        // 256-pixel frame: ledindex wraps 255 -> 0, busy continuous.
        randomize_tab(256);
        run(1'b1, 1, 1, 20 + 256 * 96 + 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ws2811_transmitter.md
Name: ws2811_transmitter

Overview:
- Serialises per-LED RGB colour onto a single WS2811 data line.
- Acts as the pixel consumer for ledcontroller: drives `ledindex`, then samples the `red`/`green`/`blue` it returns.
- Sends frames of NUM_LEDS pixels, each frame preceded by a latch/reset low gap.
- All timing is counted in `clk` cycles; defaults target a 50 MHz clock and 800 kHz WS2811 timing.

Parameters:
- NUM_LEDS, 64: pixels per frame; legal range 1..256.
- T0H, 20: high time of a '0' bit, in cycles.
- T1H, 40: high time of a '1' bit, in cycles.
- TBIT, 63: total bit period, in cycles.
- TRESET, 3000: low gap before each frame, in cycles.
- Legality: T0H < T1H < TBIT; TRESET >= 16; 24*TBIT >= 16. The 16-cycle minimum is the colour-source settle time.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  run frames continuously while high
- red  in  8  colour of the pixel addressed by ledindex
- green  in  8  colour of the pixel addressed by ledindex
- blue  in  8  colour of the pixel addressed by ledindex
- ledindex  out  8  pixel address presented to the colour source
- dout  out  1  WS2811 serial data
- busy  out  1  high while a frame (gap + pixels) is in progress
- frame_done  out  1  one-cycle pulse after the last bit of a frame

Behaviour:
- Interface decision: one clock, `clk`; reset `rst_n` is synchronous and active-low. All state updates only on posedge clk.
- Reset values, applied while rst_n=0 at a clock edge: dout=0, ledindex=0, busy=0, frame_done=0, state=IDLE, all counters 0, shift register 0.
- All outputs are registered.

State machine:
- IDLE:
  - dout=0, busy=0, ledindex=0.
  - If enable=1 -> RESET_GAP with gap counter cleared.
- RESET_GAP:
  - dout=0, busy=1, ledindex=0.
  - Lasts exactly TRESET cycles.
  - On the last cycle: load shift register with {red,green,blue} (24 bits, red MSB first); pixel counter=0.
  - Also on the last cycle: ledindex <= (NUM_LEDS>1 ? 1 : 0); -> SEND.
- SEND:
  - Bit period counter runs 0..TBIT-1.
  - dout=1 while counter < (current bit ? T1H : T0H), else 0. Each bit is exactly TBIT cycles, high time exactly T1H or T0H.
  - Bits go MSB first; no extra cycles between bits or between pixels.
  - At the end of bit 23 of pixel p < NUM_LEDS-1: load shift register from the current red/green/blue; p <= p+1.
  - At the same time, ledindex <= p+2 if p+2 < NUM_LEDS, else 0 (prefetch).
  - At the end of bit 23 of pixel NUM_LEDS-1: frame_done=1 for one cycle; ledindex <= 0.
  - After the last pixel: if enable=1 -> RESET_GAP, else -> IDLE.

Prefetch rule:
- ledindex always addresses the pixel to be sent next.
- It is stable for >= 24*TBIT cycles before being sampled, which covers the colour source's multi-cycle phase latency (<= 16 cycles).

Boundary conditions:
- enable deasserted mid-frame: the current frame completes in full, including frame_done; then -> IDLE. No truncated frames.
- enable deasserted during RESET_GAP: the gap completes and the frame is still sent.
- NUM_LEDS=1: ledindex stays 0 throughout.
- NUM_LEDS=256: ledindex wraps 255 -> 0 without overflow into a 9th bit.
- rst_n low at any point, including mid-bit: outputs return to reset values on that edge. dout drops to 0 immediately on the next edge, with no partial high pulse continuing.
- Colour inputs are sampled only at the load instants; changes at other times have no effect.

Test Plan:
- Common parameters: T0H=3, T1H=6, TBIT=10, TRESET=20, NUM_LEDS=3.
- Reset/idle: hold rst_n=0 5 cycles, enable=0 -> dout=0, ledindex=0, busy=0, frame_done=0 for 100 cycles after release.
- Single frame: colour model returns {idx*0x11, 0xA5, 0x0F}; pulse enable for one cycle and keep it high until the frame starts, then drop it.
  - dout low 20 cycles, then 72 bit periods of 10 cycles.
  - Decoded bits are 000000_00 A5 0F, then 11 A5 0F, then 22 A5 0F (high 6 = '1', high 3 = '0').
  - frame_done pulses once; then IDLE.
- Prefetch: log ledindex in the same run -> 0 during the gap, 1 at load of pixel 0, 2 at pixel 1, 0 at pixel 2.
  - Colour model with 16-cycle latency still yields correct pixels.
- Continuous run: enable held high -> frames repeat with exactly 20 low cycles between the last bit of one frame and the first rising edge of the next; frame_done period = 20 + 720 cycles.
- Mid-bit reset: assert rst_n=0 at cycle 4 of a '1' bit -> dout=0 on the next edge; after release with enable=1, a fresh full 20-cycle gap precedes pixel 0.
- Wrap: NUM_LEDS=256, TBIT=4, T0H=1, T1H=2 -> ledindex sequence ...254, 255, 0.
  - frame_done after 256 pixels; busy high continuously across the frame.
